// File: rtl/honeybee_voxel_engine_pkg.sv
// Shared types and constants for the honeybee voxel-collision engine.
package honeybee_voxel_engine_pkg;

    localparam int unsigned GRID_DIM      = 4;
    localparam int unsigned NVOX          = GRID_DIM * GRID_DIM * GRID_DIM;
    localparam int unsigned VOX_IDX_WIDTH = 6;
    localparam int unsigned AXIS_WIDTH    = 2;

    typedef enum logic [1:0] {
        HB_IDLE  = 2'd0,
        HB_BBOX  = 2'd1,
        HB_SWEEP = 2'd2,
        HB_DONE  = 2'd3
    } hb_state_t;

    // ap_return bit index for voxel (x, y, z): z*16 + y*4 + x
    function automatic logic [VOX_IDX_WIDTH-1:0] hb_vox_bit(
        input logic [AXIS_WIDTH-1:0] z,
        input logic [AXIS_WIDTH-1:0] y,
        input logic [AXIS_WIDTH-1:0] x
    );
        return {z, y, x};
    endfunction

    // Inclusive range test of one axis cell against its bounding-box extent
    function automatic logic hb_in_range(
        input logic [AXIS_WIDTH-1:0] v,
        input logic [AXIS_WIDTH-1:0] lo,
        input logic [AXIS_WIDTH-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/honeybee_voxel_engine_if.sv
// ap_ctrl_hs handshake plus edge-coordinate bus for the honeybee engine.
interface honeybee_voxel_engine_if
    import honeybee_voxel_engine_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 32
) ();

    logic                   ap_start;
    logic                   ap_done;
    logic                   ap_idle;
    logic                   ap_ready;
    logic [NVOX-1:0]        ap_return;
    logic [COORD_WIDTH-1:0] edge_p1_x;
    logic [COORD_WIDTH-1:0] edge_p1_y;
    logic [COORD_WIDTH-1:0] edge_p1_z;
    logic [COORD_WIDTH-1:0] edge_p2_x;
    logic [COORD_WIDTH-1:0] edge_p2_y;
    logic [COORD_WIDTH-1:0] edge_p2_z;

    // Core controller side
    modport master (
        output ap_start,
        output edge_p1_x, edge_p1_y, edge_p1_z,
        output edge_p2_x, edge_p2_y, edge_p2_z,
        input  ap_done, ap_idle, ap_ready, ap_return
    );

    // Accelerator side
    modport slave (
        input  ap_start,
        input  edge_p1_x, edge_p1_y, edge_p1_z,
        input  edge_p2_x, edge_p2_y, edge_p2_z,
        output ap_done, ap_idle, ap_ready, ap_return
    );

endinterface

// File: rtl/honeybee_voxel_engine_axis_range.sv
// One axis of the bounding box: two coordinates -> clamped cell range (lo, hi).
module hb_axis_range
    import honeybee_voxel_engine_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned CELL_SHIFT  = 6
) (
    input  logic [COORD_WIDTH-1:0] c1_coord,
    input  logic [COORD_WIDTH-1:0] c2_coord,
    output logic [AXIS_WIDTH-1:0]  lo,
    output logic [AXIS_WIDTH-1:0]  hi
);

    localparam logic [COORD_WIDTH-1:0] TOP_CELL_W = COORD_WIDTH'(GRID_DIM - 1);
    localparam logic [AXIS_WIDTH-1:0]  TOP_CELL   = AXIS_WIDTH'(GRID_DIM - 1);

    logic [COORD_WIDTH-1:0] s1;
    logic [COORD_WIDTH-1:0] s2;
    logic [AXIS_WIDTH-1:0]  c1;
    logic [AXIS_WIDTH-1:0]  c2;

    // Scale to cell index, saturate at the top cell, then order the pair
    always_comb begin
        s1 = c1_coord >> CELL_SHIFT;
        s2 = c2_coord >> CELL_SHIFT;
        c1 = (s1 > TOP_CELL_W) ? TOP_CELL : s1[AXIS_WIDTH-1:0];
        c2 = (s2 > TOP_CELL_W) ? TOP_CELL : s2[AXIS_WIDTH-1:0];
        lo = (c1 < c2) ? c1 : c2;
        hi = (c1 < c2) ? c2 : c1;
    end

endmodule

// File: rtl/honeybee_voxel_engine.sv
// Honeybee voxel engine: edge AABB vs 4x4x4 grid, one voxel per clock.
module honeybee_voxel_engine
    import honeybee_voxel_engine_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 32,
    parameter int unsigned CELL_SHIFT  = 6
) (
    input  logic                    clk,
    input  logic                    rstb,
    honeybee_voxel_engine_if.slave  bus
);

    hb_state_t              state_q, state_d;
    logic [COORD_WIDTH-1:0] p1_q [3];
    logic [COORD_WIDTH-1:0] p1_d [3];
    logic [COORD_WIDTH-1:0] p2_q [3];
    logic [COORD_WIDTH-1:0] p2_d [3];
    logic [AXIS_WIDTH-1:0]  lo_q [3];
    logic [AXIS_WIDTH-1:0]  lo_d [3];
    logic [AXIS_WIDTH-1:0]  hi_q [3];
    logic [AXIS_WIDTH-1:0]  hi_d [3];
    logic [AXIS_WIDTH-1:0]  rng_lo [3];
    logic [AXIS_WIDTH-1:0]  rng_hi [3];
    logic [VOX_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [NVOX-1:0]        acc_q, acc_d;
    logic [NVOX-1:0]        ret_q, ret_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   idle_q, idle_d;
    logic                   hit;

    for (genvar a = 0; a < 3; a++) begin : g_axis
        hb_axis_range #(
            .COORD_WIDTH(COORD_WIDTH),
            .CELL_SHIFT (CELL_SHIFT)
        ) u_axis (
            .c1_coord(p1_q[a]),
            .c2_coord(p2_q[a]),
            .lo      (rng_lo[a]),
            .hi      (rng_hi[a])
        );
    end

    // Next-state, datapath and registered handshake outputs
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ret_d   = ret_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        hit     = hb_in_range(idx_q[1:0], lo_q[0], hi_q[0])
                & hb_in_range(idx_q[3:2], lo_q[1], hi_q[1])
                & hb_in_range(idx_q[5:4], lo_q[2], hi_q[2]);
        case (state_q)
            HB_IDLE: begin
                if (bus.ap_start) begin
                    p1_d    = '{bus.edge_p1_x, bus.edge_p1_y, bus.edge_p1_z};
                    p2_d    = '{bus.edge_p2_x, bus.edge_p2_y, bus.edge_p2_z};
                    acc_d   = '0;
                    ready_d = 1'b1;
                    state_d = HB_BBOX;
                end
            end
            HB_BBOX: begin
                lo_d    = rng_lo;
                hi_d    = rng_hi;
                idx_d   = '0;
                state_d = HB_SWEEP;
            end
            HB_SWEEP: begin
                acc_d[idx_q] = hit;
                idx_d        = idx_q + 1'b1;
                if (idx_q == '1) begin
                    // Result is loaded on entry to DONE so it is valid alongside ap_done
                    ret_d   = acc_d;
                    done_d  = 1'b1;
                    state_d = HB_DONE;
                end
            end
            HB_DONE: begin
                state_d = HB_IDLE;
            end
            default: state_d = HB_IDLE;
        endcase
        idle_d = (state_d == HB_IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= HB_IDLE;
            p1_q    <= '{default: '0};
            p2_q    <= '{default: '0};
            lo_q    <= '{default: '0};
            hi_q    <= '{default: '0};
            idx_q   <= '0;
            acc_q   <= '0;
            ret_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            ret_q   <= ret_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.ap_done   = done_q;
    assign bus.ap_ready  = ready_q;
    assign bus.ap_idle   = idle_q;
    assign bus.ap_return = ret_q;

endmodule

// File: tb/tb_honeybee_voxel_engine.sv
// Self-checking bench for honeybee_voxel_engine.
module tb_honeybee_voxel_engine;
    import honeybee_voxel_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rstb;
    int unsigned cyc = 0;
    int unsigned passed = 0;
    int unsigned total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    honeybee_voxel_engine_if #(.COORD_WIDTH(32)) bus ();

    honeybee_voxel_engine #(
        .COORD_WIDTH(32),
        .CELL_SHIFT (6)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: cell = min(coord/64, 3); set every voxel inside the box
    function automatic int unsigned cell_of(input logic [31:0] v);
        int unsigned c;
        c = v / 64;
        return (c > 3) ? 3 : c;
    endfunction

    function automatic logic [63:0] model_bitmap(input logic [31:0] ax, ay, az, bx, by, bz);
        logic [63:0] bm;
        int unsigned lx, hx, ly, hy, lz, hz;
        lx = cell_of(ax) < cell_of(bx) ? cell_of(ax) : cell_of(bx);
        hx = cell_of(ax) < cell_of(bx) ? cell_of(bx) : cell_of(ax);
        ly = cell_of(ay) < cell_of(by) ? cell_of(ay) : cell_of(by);
        hy = cell_of(ay) < cell_of(by) ? cell_of(by) : cell_of(ay);
        lz = cell_of(az) < cell_of(bz) ? cell_of(az) : cell_of(bz);
        hz = cell_of(az) < cell_of(bz) ? cell_of(bz) : cell_of(az);
        bm = '0;
        for (int unsigned z = lz; z <= hz; z++)
            for (int unsigned y = ly; y <= hy; y++)
                for (int unsigned x = lx; x <= hx; x++)
                    bm[z*16 + y*4 + x] = 1'b1;
        return bm;
    endfunction

    // Timeline model: m_n is the cycle number within the running job (1..66)
    logic        m_busy;
    int unsigned m_n;
    logic [63:0] m_ret, m_job;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_busy <= 1'b0;
            m_n    <= 0;
            m_ret  <= '0;
        end else if (m_busy) begin
            m_n <= m_n + 1;
            if (m_n + 1 == 66) m_ret <= m_job;
            if (m_n + 1 == 67) m_busy <= 1'b0;
        end else if (bus.ap_start) begin
            m_busy <= 1'b1;
            m_n    <= 1;
            m_job  <= model_bitmap(bus.edge_p1_x, bus.edge_p1_y, bus.edge_p1_z,
                                   bus.edge_p2_x, bus.edge_p2_y, bus.edge_p2_z);
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        check("cyc_idle",   64'(bus.ap_idle),  64'(!m_busy));
        check("cyc_ready",  64'(bus.ap_ready), 64'(m_busy && m_n == 1));
        check("cyc_done",   64'(bus.ap_done),  64'(m_busy && m_n == 66));
        check("cyc_return", bus.ap_return,     m_ret);
    end

    task automatic set_pts(input logic [31:0] ax, ay, az, bx, by, bz);
        bus.edge_p1_x = ax; bus.edge_p1_y = ay; bus.edge_p1_z = az;
        bus.edge_p2_x = bx; bus.edge_p2_y = by; bus.edge_p2_z = bz;
    endtask

    task automatic rand_pts();
        set_pts($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    // One job from IDLE; optional coordinate change plus stray start at cycle chg
    task automatic run_job(input string name, input logic [31:0] ax, ay, az, bx, by, bz,
                           input logic [63:0] exp, input int unsigned chg);
        int unsigned c0, lat;
        logic        got;
        logic [63:0] ret;
        @(negedge clk); #2;
        set_pts(ax, ay, az, bx, by, bz);
        bus.ap_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        check({name, "_ready_c1"}, 64'(bus.ap_ready), 64'd1);
        #2 bus.ap_start = 1'b0;
        got = 1'b0; lat = 0; ret = '0;
        for (int unsigned i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (bus.ap_done) begin
                got = 1'b1; lat = cyc - c0; ret = bus.ap_return;
            end else if (chg != 0) begin
                if (cyc - c0 == chg) begin
                    #2 set_pts(0, 0, 0, 0, 0, 0);
                    bus.ap_start = 1'b1;
                end else if (cyc - c0 == chg + 1) begin
                    #2 bus.ap_start = 1'b0;
                end
            end
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
        check({name, "_latency"},   64'(lat), 64'd66);
        check({name, "_return"},    ret,      exp);
    endtask

    initial begin
        int unsigned c0, n, dones;
        int unsigned done_at [3];

        // Model pinned against hand-computed bitmaps
        check("model_single", model_bitmap(0, 0, 0, 0, 0, 0), 64'h0000_0000_0000_0001);
        check("model_diag",   model_bitmap(0, 0, 0, 255, 255, 255), 64'hFFFF_FFFF_FFFF_FFFF);
        check("model_xrow",   model_bitmap(255, 127, 191, 0, 64, 128), 64'h0000_00F0_0000_0000);
        check("model_clamp",  model_bitmap(32'h1000, 0, 32'hFFFF_FFFF, 32'h1000, 0, 32'hFFFF_FFFF),
              64'h0008_0000_0000_0000);

        // Reset held with random inputs
        rstb = 1'b0;
        bus.ap_start = 1'(($urandom % 2));
        rand_pts();
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_idle",   64'(bus.ap_idle),  64'd1);
            check("rst_done",   64'(bus.ap_done),  64'd0);
            check("rst_ready",  64'(bus.ap_ready), 64'd0);
            check("rst_return", bus.ap_return,     64'd0);
            #2 bus.ap_start = 1'(($urandom % 2));
            rand_pts();
        end
        @(negedge clk); #2;
        bus.ap_start = 1'b0;
        rstb = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 64'(bus.ap_idle), 64'd1);

        run_job("single", 0, 0, 0, 0, 0, 0, 64'h0000_0000_0000_0001, 0);
        run_job("diag",   0, 0, 0, 255, 255, 255, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_job("xrow",   255, 127, 191, 0, 64, 128, 64'h0000_00F0_0000_0000, 0);
        run_job("clamp",  32'h1000, 0, 32'hFFFF_FFFF, 32'h1000, 0, 32'hFFFF_FFFF,
                64'h0008_0000_0000_0000, 0);

        // ap_start held high across three jobs
        @(negedge clk); #2;
        set_pts(0, 0, 0, 255, 255, 255);
        bus.ap_start = 1'b1;
        c0 = cyc;
        n = 0;
        done_at = '{0, 0, 0};
        for (int unsigned i = 0; i < 230 && n < 3; i++) begin
            @(negedge clk);
            if (bus.ap_done) begin
                done_at[n] = cyc - c0;
                n++;
            end
        end
        #2 bus.ap_start = 1'b0;
        check("held_count", 64'(n), 64'd3);
        check("held_done1", 64'(done_at[0]), 64'd66);
        check("held_done2", 64'(done_at[1]), 64'd133);
        check("held_done3", 64'(done_at[2]), 64'd200);
        repeat (2) @(negedge clk);

        // Reset pulsed mid-sweep: no done, result cleared
        #2;
        set_pts(255, 127, 191, 0, 64, 128);
        bus.ap_start = 1'b1;
        c0 = cyc;
        @(negedge clk); #2 bus.ap_start = 1'b0;
        while (cyc - c0 < 30) @(negedge clk);
        #2 rstb = 1'b0;
        @(negedge clk);
        check("midrst_return", bus.ap_return, 64'd0);
        check("midrst_idle",   64'(bus.ap_idle), 64'd1);
        #2 rstb = 1'b1;
        dones = 0;
        for (int unsigned i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.ap_done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        run_job("after_rst", 32'h1000, 0, 32'hFFFF_FFFF, 32'h1000, 0, 32'hFFFF_FFFF,
                64'h0008_0000_0000_0000, 0);

        // Inputs changed (and start re-pulsed) at cycle 5 of a running job
        run_job("chg5", 255, 127, 191, 0, 64, 128, 64'h0000_00F0_0000_0000, 5);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
